// File: rtl/rv_decode_pipe.sv
// RV64I decode stage: register file with write-back forwarding, opcode decode into a
// registered uop, load-use interlock, flush and stall counting behind a valid/ready handshake.
module rv_decode_pipe #(
  parameter int XLEN   = 64,
  parameter int NUM_WB = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  input  logic [NUM_WB-1:0]        wb_en,
  input  logic [5*NUM_WB-1:0]      wb_rd,
  input  logic [XLEN*NUM_WB-1:0]   wb_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [2:0]               out_mem_para,
  output logic [XLEN-1:0]          out_op1,
  output logic [XLEN-1:0]          out_op2,
  output logic [XLEN-1:0]          out_store_value,
  output logic [XLEN-1:0]          out_target,
  output logic [XLEN-1:0]          out_pc,
  output logic                     out_write_back,
  output logic                     out_imm_flag,
  output logic                     out_mem_acc,
  output logic                     out_load_flag,
  output logic                     out_word_inst,
  output logic                     out_branch_flag,
  output logic                     out_jump_flag,
  output logic                     out_illegal,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      mem_para;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] store_value;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            write_back;
    logic            imm_flag;
    logic            mem_acc;
    logic            load_flag;
    logic            word_inst;
    logic            branch_flag;
    logic            jump_flag;
    logic            illegal;
  } uop_t;

  logic [4:0]      wb_rd_a  [NUM_WB];
  logic [XLEN-1:0] wb_val_a [NUM_WB];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WB; gi++) begin : g_wb_split
      assign wb_rd_a[gi]  = wb_rd[5*gi +: 5];
      assign wb_val_a[gi] = wb_value[XLEN*gi +: XLEN];
    end
  endgenerate

  logic [XLEN-1:0] regs [32];

  // Descending loop so the lowest-index port's write lands last and wins.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 32; r++) regs[r] <= '0;
    end else begin
      for (int k = NUM_WB - 1; k >= 0; k--) begin
        if (wb_en[k] && wb_rd_a[k] != 5'd0) regs[wb_rd_a[k]] <= wb_val_a[k];
      end
    end
  end

  logic [6:0]      opcode;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode = in_inst[6:0];
  assign rd_f   = in_inst[11:7];
  assign rs1_f  = in_inst[19:15];
  assign rs2_f  = in_inst[24:20];

  always_comb begin
    rs1_val = regs[rs1_f];
    rs2_val = regs[rs2_f];
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (wb_en[k] && wb_rd_a[k] == rs1_f && rs1_f != 5'd0) rs1_val = wb_val_a[k];
      if (wb_en[k] && wb_rd_a[k] == rs2_f && rs2_f != 5'd0) rs2_val = wb_val_a[k];
    end
  end

  logic signed [11:0] i12;
  logic signed [11:0] s12;
  logic signed [12:0] b13;
  logic signed [20:0] j21;
  logic signed [31:0] u32;
  logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_j, imm_u;

  assign i12   = in_inst[31:20];
  assign s12   = {in_inst[31:25], in_inst[11:7]};
  assign b13   = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign j21   = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign u32   = {in_inst[31:12], 12'b0};
  assign imm_i = XLEN'(i12);
  assign imm_s = XLEN'(s12);
  assign imm_b = XLEN'(b13);
  assign imm_j = XLEN'(j21);
  assign imm_u = XLEN'(u32);

  uop_t dec;
  logic reads_rs1, reads_rs2;

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP32: begin
        reads_rs1 = 1'b1;  reads_rs2 = 1'b1;
        dec.rd = rd_f;  dec.rs1 = rs1_f;  dec.rs2 = rs2_f;
        dec.funct3 = in_inst[14:12];  dec.funct7 = in_inst[31:25];
        dec.op1 = rs1_val;  dec.op2 = rs2_val;
        dec.write_back = 1'b1;
        dec.word_inst  = (opcode == OPC_OP32);
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        reads_rs1 = 1'b1;
        dec.rd = rd_f;  dec.rs1 = rs1_f;
        dec.funct3 = in_inst[14:12];  dec.funct7 = in_inst[31:25];
        dec.op1 = rs1_val;  dec.op2 = imm_i;
        dec.imm_flag   = 1'b1;
        dec.write_back = 1'b1;
        dec.word_inst  = (opcode == OPC_OPIMM32);
      end
      OPC_LOAD: begin
        reads_rs1 = 1'b1;
        dec.rd = rd_f;  dec.rs1 = rs1_f;
        dec.mem_para = in_inst[14:12];
        dec.op1 = rs1_val;  dec.op2 = imm_i;
        dec.mem_acc = 1'b1;  dec.load_flag = 1'b1;  dec.write_back = 1'b1;
      end
      OPC_STORE: begin
        reads_rs1 = 1'b1;  reads_rs2 = 1'b1;
        dec.rs1 = rs1_f;  dec.rs2 = rs2_f;
        dec.mem_para = in_inst[14:12];
        dec.op1 = rs1_val;  dec.op2 = imm_s;
        dec.store_value = rs2_val;
        dec.mem_acc = 1'b1;
      end
      OPC_BRANCH: begin
        reads_rs1 = 1'b1;  reads_rs2 = 1'b1;
        dec.rs1 = rs1_f;  dec.rs2 = rs2_f;
        dec.funct3 = in_inst[14:12];
        dec.op1 = rs1_val;  dec.op2 = rs2_val;
        dec.branch_flag = 1'b1;
        dec.target = in_pc + imm_b;
      end
      OPC_JAL: begin
        dec.rd = rd_f;
        dec.op1 = in_pc;  dec.op2 = XLEN'(4);
        dec.write_back = 1'b1;  dec.jump_flag = 1'b1;
        dec.target = in_pc + imm_j;
      end
      OPC_JALR: begin
        reads_rs1 = 1'b1;
        dec.rd = rd_f;  dec.rs1 = rs1_f;
        dec.funct3 = in_inst[14:12];
        dec.op1 = in_pc;  dec.op2 = XLEN'(4);
        dec.write_back = 1'b1;  dec.jump_flag = 1'b1;
        dec.target = (rs1_val + imm_i) & ~(XLEN'(1));
      end
      OPC_LUI: begin
        dec.rd = rd_f;
        dec.op2 = imm_u;
        dec.write_back = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd = rd_f;
        dec.op1 = in_pc;  dec.op2 = imm_u;
        dec.write_back = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  uop_t             uop_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_q;
  logic             hazard;

  assign hazard = valid_q && uop_q.load_flag && uop_q.rd != 5'd0 &&
                  ((reads_rs1 && rs1_f == uop_q.rd) || (reads_rs2 && rs2_f == uop_q.rd));
  assign in_ready = !flush && !hazard && (!valid_q || out_ready);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      uop_q   <= '0;
      stall_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (in_valid && in_ready) begin
        uop_q   <= dec;
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (hazard && in_valid && !flush) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign out_valid       = valid_q;
  assign out_rd          = uop_q.rd;
  assign out_rs1         = uop_q.rs1;
  assign out_rs2         = uop_q.rs2;
  assign out_funct3      = uop_q.funct3;
  assign out_funct7      = uop_q.funct7;
  assign out_mem_para    = uop_q.mem_para;
  assign out_op1         = uop_q.op1;
  assign out_op2         = uop_q.op2;
  assign out_store_value = uop_q.store_value;
  assign out_target      = uop_q.target;
  assign out_pc          = uop_q.pc;
  assign out_write_back  = uop_q.write_back;
  assign out_imm_flag    = uop_q.imm_flag;
  assign out_mem_acc     = uop_q.mem_acc;
  assign out_load_flag   = uop_q.load_flag;
  assign out_word_inst   = uop_q.word_inst;
  assign out_branch_flag = uop_q.branch_flag;
  assign out_jump_flag   = uop_q.jump_flag;
  assign out_illegal     = uop_q.illegal;
  assign stall_cycles    = stall_q;

endmodule
